// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared defaults and state encodings for the UART line controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int         c_depth_default = 16;
    localparam logic [7:0] c_eol_default   = 8'h0D;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        READY   = 1'b1
    } line_state_t;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_START = 2'd1,
        E_WAIT  = 2'd2
    } echo_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_line_buf.sv
// ============================================================================
// Module   : uart_line_buf
// Brief    : DEPTH x 8 line storage, one synchronous write, one async read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_line_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = c_depth_default
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data
);

    // Contents are deliberately left unreset; software only reads up to line_len.
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_line_ctrl.sv
// ============================================================================
// Module   : uart_line_ctrl
// Brief    : Collects received bytes into a line buffer for the CPU; optional
//            byte echo to the transmitter when UART_LINE_ECHO_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_line_ctrl
    import uart_pkg::*;
#(
    parameter int         DEPTH    = c_depth_default,
    parameter logic [7:0] EOL_CHAR = c_eol_default
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   line_len,
    output logic                     line_ready,
    input  logic                     line_ack,
    output logic                     overflow
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam int              c_lw   = c_aw + 1;
    localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);

    line_state_t     r_state, w_state_nxt;
    logic [c_lw-1:0] r_len, w_len_nxt;
    logic            r_ovf, w_ovf_nxt;
    logic            w_wr_en;
    logic [c_aw-1:0] w_wr_addr;
    logic            w_accept;
    logic            w_is_eol;

    assign w_is_eol = (rx_data == EOL_CHAR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= COLLECT;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // w_accept marks a byte taken into the line (stored or terminator); only those are echoed.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_ovf_nxt   = r_ovf;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_len[c_aw-1:0];
        w_accept    = 1'b0;
        case (r_state)
            COLLECT: begin
                if (rx_valid) begin
                    if (w_is_eol) begin
                        w_state_nxt = READY;
                        w_accept    = 1'b1;
                    end else if (r_len < c_full) begin
                        w_wr_en   = 1'b1;
                        w_len_nxt = r_len + 1'b1;
                        w_accept  = 1'b1;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
            end
            READY: begin
                if (line_ack) begin
                    w_state_nxt = COLLECT;
                    w_len_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    if (rx_valid) begin
                        w_accept = 1'b1;
                        if (w_is_eol) begin
                            w_state_nxt = READY;
                        end else begin
                            w_wr_en   = 1'b1;
                            w_wr_addr = '0;
                            w_len_nxt = c_lw'(1);
                        end
                    end
                end else if (rx_valid) begin
                    w_ovf_nxt = 1'b1;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    uart_line_buf #(
        .DEPTH   (DEPTH)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign line_len   = r_len;
    assign line_ready = (r_state == READY);
    assign overflow   = r_ovf;

`ifdef UART_LINE_ECHO_EN
    echo_state_t r_echo, w_echo_nxt;
    logic [7:0]  r_echo_data, w_echo_data_nxt;
    logic        r_slot_vld, w_slot_vld_nxt;
    logic [7:0]  r_slot_data, w_slot_data_nxt;
    logic        r_busy_seen, w_busy_seen_nxt;
    logic        r_wait_cnt, w_wait_cnt_nxt;
    logic        w_tx_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_echo      <= E_IDLE;
            r_echo_data <= 8'h00;
            r_slot_vld  <= 1'b0;
            r_slot_data <= 8'h00;
            r_busy_seen <= 1'b0;
            r_wait_cnt  <= 1'b0;
        end else begin
            r_echo      <= w_echo_nxt;
            r_echo_data <= w_echo_data_nxt;
            r_slot_vld  <= w_slot_vld_nxt;
            r_slot_data <= w_slot_data_nxt;
            r_busy_seen <= w_busy_seen_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    // Once tx_start has fired, tx_data is frozen; later bytes go to the one-deep slot.
    always_comb begin
        w_echo_nxt      = r_echo;
        w_echo_data_nxt = r_echo_data;
        w_slot_vld_nxt  = r_slot_vld;
        w_slot_data_nxt = r_slot_data;
        w_busy_seen_nxt = r_busy_seen;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_tx_start      = 1'b0;
        case (r_echo)
            E_IDLE: begin
                if (w_accept) begin
                    w_echo_data_nxt = rx_data;
                    w_echo_nxt      = E_START;
                end
            end
            E_START: begin
                if (!tx_busy) begin
                    w_tx_start      = 1'b1;
                    w_echo_nxt      = E_WAIT;
                    w_busy_seen_nxt = 1'b0;
                    w_wait_cnt_nxt  = 1'b0;
                    if (w_accept) begin
                        w_slot_vld_nxt  = 1'b1;
                        w_slot_data_nxt = rx_data;
                    end
                end else if (w_accept) begin
                    w_echo_data_nxt = rx_data;
                end
            end
            E_WAIT: begin
                if (w_accept) begin
                    w_slot_vld_nxt  = 1'b1;
                    w_slot_data_nxt = rx_data;
                end
                w_busy_seen_nxt = r_busy_seen | tx_busy;
                w_wait_cnt_nxt  = 1'b1;
                // Leave on busy falling, or on the second cycle if busy never rose.
                if (!tx_busy && (r_busy_seen || r_wait_cnt)) begin
                    if (w_slot_vld_nxt) begin
                        w_echo_data_nxt = w_slot_data_nxt;
                        w_slot_vld_nxt  = 1'b0;
                        w_echo_nxt      = E_START;
                    end else begin
                        w_echo_nxt = E_IDLE;
                    end
                end
            end
            default: w_echo_nxt = E_IDLE;
        endcase
    end

    assign tx_start = w_tx_start;
    assign tx_data  = r_echo_data;
`else
    logic w_unused;

    assign w_unused = &{1'b0, tx_busy, w_accept};
    assign tx_start = 1'b0;
    assign tx_data  = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_line_ctrl.sv
// ============================================================================
// Module   : tb_uart_line_ctrl
// Brief    : Self-checking bench for uart_line_ctrl (echo checks follow
//            UART_LINE_ECHO_EN).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_line_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef UART_LINE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          rx_valid   = 1'b0;
    logic [7:0]    rx_data    = 8'h00;
    logic          line_ack   = 1'b0;
    logic          force_busy = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [7:0]    rd_data;
    logic [AW:0]   line_len;
    logic          line_ready;
    logic          overflow;

    int busy_cnt = 0;
    int busy_len = 3;
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] txq[$];
    logic [7:0] expq[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a;
        int         gap;
        int         len;
        logic       rdy;
        logic       ovf;
    } vec_t;

    vec_t tbl [14];

    assign tx_busy = force_busy | (busy_cnt != 0);

    always #5 clk = ~clk;

    uart_line_ctrl #(
        .DEPTH      (DEPTH),
        .EOL_CHAR   (8'h0D)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .line_len   (line_len),
        .line_ready (line_ready),
        .line_ack   (line_ack),
        .overflow   (overflow)
    );

    // Transmitter model: logs every tx_start and stays busy for busy_len cycles.
    initial begin
        logic s;
        forever begin
            @(negedge clk);
            s = tx_start;
            if (s) txq.push_back(tx_data);
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (s) busy_cnt = busy_len;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_tx(input logic [7:0] b);
        if (ECHO) expq.push_back(b);
    endtask

    task automatic check_tx(input string name);
        check({name, "_count"}, 32'(txq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), 32'(txq[i]), 32'(expq[i]));
        end
        txq.delete();
        expq.delete();
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic a);
        rx_valid = v;
        rx_data  = d;
        line_ack = a;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        line_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_rd(input string name, input int idx, input logic [7:0] exp);
        rd_addr = AW'(idx);
        #1;
        check($sformatf("%s_rd%0d", name, idx), 32'(rd_data), 32'(exp));
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].a);
            check($sformatf("vec%0d_len", i), 32'(line_len), 32'(tbl[i].len));
            check($sformatf("vec%0d_ready", i), 32'(line_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            idle(tbl[i].gap);
        end
    endtask

    initial begin
        //          v     data   ack   gap len rdy   ovf
        tbl[0]  = '{1'b1, 8'h35, 1'b0, 5, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h37, 1'b0, 5, 2, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h38, 1'b0, 5, 3, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h0D, 1'b0, 5, 3, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 2, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h31, 1'b0, 5, 1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 2, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h34, 1'b0, 5, 2, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h0D, 1'b0, 5, 2, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h41, 1'b0, 5, 2, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 8'h42, 1'b1, 5, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h0D, 1'b0, 5, 1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'h0D, 1'b1, 5, 0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 2, 0, 1'b0, 1'b0};

        // Reset values
        idle(2);
        check("rst_len", 32'(line_len), 32'd0);
        check("rst_ready", 32'(line_ready), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        resetn = 1'b1;
        idle(1);

        // First line and its echo
        run_tbl(0, 3);
        check_rd("line1", 0, 8'h35);
        check_rd("line1", 1, 8'h37);
        check_rd("line1", 2, 8'h38);
        expect_tx(8'h35); expect_tx(8'h37); expect_tx(8'h38); expect_tx(8'h0D);
        check_tx("echo_line1");

        // Ack, ack ignored while collecting, second line; index 2 keeps old byte
        run_tbl(4, 8);
        check_rd("line2", 0, 8'h31);
        check_rd("line2", 1, 8'h34);
        check_rd("line2", 2, 8'h38);
        expect_tx(8'h31); expect_tx(8'h34); expect_tx(8'h0D);
        check_tx("echo_line2");

        // Byte while READY dropped; ack with simultaneous byte
        run_tbl(9, 10);
        check_rd("ackbyte", 0, 8'h42);
        expect_tx(8'h42);
        check_tx("echo_ackbyte");

        // Ack with simultaneous EOL gives an empty ready line
        run_tbl(11, 13);
        expect_tx(8'h0D); expect_tx(8'h0D);
        check_tx("echo_empty");

        // Overflow: DEPTH+2 bytes then EOL
        for (int i = 0; i < DEPTH + 2; i++) begin
            cyc(1'b1, 8'(8'h50 + i), 1'b0);
            check($sformatf("ovf_len%0d", i), 32'(line_len), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
            check($sformatf("ovf_flag%0d", i), 32'(overflow), 32'(i >= DEPTH));
            if (i < DEPTH) expect_tx(8'(8'h50 + i));
            idle(5);
        end
        cyc(1'b1, 8'h0D, 1'b0);
        check("ovf_final_len", 32'(line_len), 32'(DEPTH));
        check("ovf_final_ready", 32'(line_ready), 32'd1);
        check("ovf_final_flag", 32'(overflow), 32'd1);
        expect_tx(8'h0D);
        idle(5);
        check_tx("echo_ovf");
        for (int i = 0; i < DEPTH; i++) check_rd("ovf", i, 8'(8'h50 + i));
        cyc(1'b0, 8'h00, 1'b1);
        check("ovf_ack_len", 32'(line_len), 32'd0);
        check("ovf_ack_flag", 32'(overflow), 32'd0);
        idle(3);

        // Long busy: only the first and the last queued byte go out
        cyc(1'b1, 8'h61, 1'b0);
        idle(1);
        force_busy = 1'b1;
        cyc(1'b1, 8'h62, 1'b0);
        idle(3);
        cyc(1'b1, 8'h63, 1'b0);
        idle(500);
        check("busy_hold_tx_data", 32'(tx_data), ECHO ? 32'h61 : 32'h00);
        check("busy_len", 32'(line_len), 32'd3);
        force_busy = 1'b0;
        idle(10);
        expect_tx(8'h61); expect_tx(8'h63);
        check_tx("echo_busy");

        // Busy never asserted: the wait state times out and the queued byte follows
        busy_len = 0;
        cyc(1'b1, 8'h71, 1'b0);
        cyc(1'b1, 8'h72, 1'b0);
        idle(8);
        expect_tx(8'h71); expect_tx(8'h72);
        check_tx("echo_nobusy");
        check("nobusy_len", 32'(line_len), 32'd5);
        busy_len = 3;

        // Reset while waiting on the transmitter with a byte queued
        cyc(1'b1, 8'h75, 1'b0);
        idle(1);
        cyc(1'b1, 8'h76, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_len", 32'(line_len), 32'd0);
        check("midrst_ready", 32'(line_ready), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        expect_tx(8'h75);
        check_tx("echo_before_rst");
        idle(2);
        resetn = 1'b1;
        idle(20);
        check("no_tx_after_rst", 32'(txq.size()), 32'd0);
        check("post_rst_len", 32'(line_len), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
